// File: rtl/omp_iter_seq.sv
// Multi-iteration OMP sequencer: copies y rows 0..M into residual RAM r, then runs K rounds of
// Block A (argmax) -> support-set record -> residual update, with range/duplicate/timeout checks.
module omp_iter_seq #(
  parameter int DATA_W  = 96,
  parameter int ADDR_W  = 3,
  parameter int IDX_W   = 6,
  parameter int K_MAX   = 8,
  parameter int Y_LAT   = 1,
  parameter int TIMEOUT = 4096,
  localparam int KW     = $clog2(K_MAX) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  N,
  input  logic [ADDR_W-1:0] M,
  input  logic [KW-1:0]     K,
  output logic [ADDR_W-1:0] y_addr,
  input  logic [DATA_W-1:0] y_data,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_wdata,
  output logic              a_start,
  input  logic              a_done,
  input  logic [IDX_W-1:0]  a_lambda,
  output logic              upd_start,
  input  logic              upd_done,
  output logic              supp_we,
  output logic [KW-1:0]     supp_addr,
  output logic [IDX_W-1:0]  supp_idx,
  output logic [KW-1:0]     iter_cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int DW  = (Y_LAT > 1) ? $clog2(Y_LAT) : 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_DRAIN, S_RUN_A, S_RECORD, S_RUN_U, S_DONE, S_ERR
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   n_q;
  logic [ADDR_W-1:0]  m_q;
  logic [KW-1:0]      k_q;
  logic [ADDR_W-1:0]  y_addr_q;
  logic               rd_vld_q  [Y_LAT];
  logic [ADDR_W-1:0]  rd_addr_q [Y_LAT];
  logic [DW-1:0]      drain_q;
  logic [WDW-1:0]     wd_q;
  logic               a_start_q, upd_start_q, supp_we_q, done_q;
  logic [KW-1:0]      supp_addr_q, iter_cnt_q;
  logic [IDX_W-1:0]   supp_idx_q;
  logic [1:0]         err_code_q;
  logic               rng_q, dup_q;
  logic [K_MAX-1:0]   vld_q;
  logic [IDX_W-1:0]   supp_mem_q [K_MAX];

  logic [KW-1:0]      k_clamp_d, iter_nxt_d;
  logic               rng_d, dup_d, wd_exp_d;

  always_comb begin
    k_clamp_d  = (K > KW'(K_MAX)) ? KW'(K_MAX) : K;
    iter_nxt_d = iter_cnt_q + KW'(1);
    rng_d      = a_lambda > n_q;
    dup_d      = 1'b0;
    for (int unsigned i = 0; i < K_MAX; i++) begin
      if (vld_q[i] && (supp_mem_q[i] == a_lambda)) dup_d = 1'b1;
    end
    // Expires on the wait cycle where the counter would reach TIMEOUT; a done on that cycle still wins.
    wd_exp_d   = (TIMEOUT != 0) && (wd_q == WDW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      m_q         <= '0;
      k_q         <= '0;
      y_addr_q    <= '0;
      drain_q     <= '0;
      wd_q        <= '0;
      a_start_q   <= 1'b0;
      upd_start_q <= 1'b0;
      supp_we_q   <= 1'b0;
      done_q      <= 1'b0;
      supp_addr_q <= '0;
      supp_idx_q  <= '0;
      iter_cnt_q  <= '0;
      err_code_q  <= '0;
      rng_q       <= 1'b0;
      dup_q       <= 1'b0;
      vld_q       <= '0;
      for (int unsigned i = 0; i < Y_LAT; i++) begin
        rd_vld_q[i]  <= 1'b0;
        rd_addr_q[i] <= '0;
      end
      for (int unsigned i = 0; i < K_MAX; i++) supp_mem_q[i] <= '0;
    end else begin
      rd_vld_q[0]  <= (state_q == S_INIT);
      rd_addr_q[0] <= y_addr_q;
      for (int unsigned i = 1; i < Y_LAT; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_addr_q[i] <= rd_addr_q[i-1];
      end
      a_start_q   <= 1'b0;
      upd_start_q <= 1'b0;
      supp_we_q   <= 1'b0;
      done_q      <= 1'b0;
      wd_q        <= wd_q + WDW'(1);

      case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            n_q        <= N;
            m_q        <= M;
            k_q        <= k_clamp_d;
            iter_cnt_q <= '0;
            vld_q      <= '0;
            err_code_q <= '0;
            y_addr_q   <= '0;
            if (k_clamp_d == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_INIT;
            end
          end
        end
        S_INIT: begin
          if (y_addr_q == m_q) begin
            state_q <= S_DRAIN;
            drain_q <= '0;
          end else begin
            y_addr_q <= y_addr_q + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_q == DW'(Y_LAT - 1)) begin
            state_q   <= S_RUN_A;
            a_start_q <= 1'b1;
            wd_q      <= '0;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        S_RUN_A: begin
          // a_start_q marks the launch cycle, where a_done is not yet sampled.
          if (!a_start_q && a_done) begin
            state_q     <= S_RECORD;
            supp_idx_q  <= a_lambda;
            supp_addr_q <= iter_cnt_q;
            rng_q       <= rng_d;
            dup_q       <= dup_d;
            supp_we_q   <= !rng_d && !dup_d;
          end else if (wd_exp_d) begin
            state_q    <= S_ERR;
            err_code_q <= 2'b11;
          end
        end
        S_RECORD: begin
          if (rng_q) begin
            state_q    <= S_ERR;
            err_code_q <= 2'b01;
          end else if (dup_q) begin
            state_q    <= S_ERR;
            err_code_q <= 2'b10;
          end else begin
            for (int unsigned i = 0; i < K_MAX; i++) begin
              if (KW'(i) == iter_cnt_q) begin
                vld_q[i]      <= 1'b1;
                supp_mem_q[i] <= supp_idx_q;
              end
            end
            state_q     <= S_RUN_U;
            upd_start_q <= 1'b1;
            wd_q        <= '0;
          end
        end
        S_RUN_U: begin
          if (upd_done) begin
            iter_cnt_q <= iter_nxt_d;
            if (iter_nxt_d == k_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RUN_A;
              a_start_q <= 1'b1;
              wd_q      <= '0;
            end
          end else if (wd_exp_d) begin
            state_q    <= S_ERR;
            err_code_q <= 2'b11;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign y_addr    = y_addr_q;
  assign r_we      = rd_vld_q[Y_LAT-1];
  assign r_addr    = rd_addr_q[Y_LAT-1];
  assign r_wdata   = r_we ? y_data : '0;
  assign a_start   = a_start_q;
  assign upd_start = upd_start_q;
  assign supp_we   = supp_we_q;
  assign supp_addr = supp_addr_q;
  assign supp_idx  = supp_idx_q;
  assign iter_cnt  = iter_cnt_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_ERR);
  assign done      = done_q;
  assign err       = (state_q == S_ERR);
  assign err_code  = err_code_q;

endmodule
